// File: rtl/alu_issue_seq.sv
// Sequencer that fetches 16-bit ALU instructions from a registered ROM
// and issues them one at a time over a valid/ready handshake.
module alu_issue_seq #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [3:0]      iss_op,
  output logic [1:0]      iss_rd,
  output logic [1:0]      iss_rs,
  output logic [5:0]      iss_imm,
  output logic            running,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     icount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    HALTED
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hD;

  state_t          state, state_d;
  logic [PC_W-1:0] pc_d;
  logic            valid_d;
  logic [3:0]      op_d;
  logic [1:0]      rd_d;
  logic [1:0]      rs_d;
  logic [5:0]      imm_d;
  logic            running_d;
  logic            halted_d;
  logic            illegal_d;
  logic [15:0]     icount_d;
  logic            accept;

  // imem_addr is the program counter itself
  assign accept = iss_valid & iss_ready;

  always_comb begin
    state_d   = state;
    pc_d      = imem_addr;
    valid_d   = iss_valid;
    op_d      = iss_op;
    rd_d      = iss_rd;
    rs_d      = iss_rs;
    imm_d     = iss_imm;
    illegal_d = 1'b0;
    icount_d  = icount;
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_d     = '0;
          icount_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (imem_rdata[15:13] == 3'b111) begin
          illegal_d = 1'b1;
          pc_d      = imem_addr + PC_W'(1);
          state_d   = FETCH;
        end else begin
          op_d    = imem_rdata[15:12];
          rd_d    = imem_rdata[11:10];
          rs_d    = imem_rdata[9:8];
          imm_d   = imem_rdata[5:0];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          valid_d = 1'b0;
          if (icount != 16'hFFFF)
            icount_d = icount + 16'd1;
          if (iss_op == OP_HALT) begin
            state_d = HALTED;
          end else begin
            pc_d    = imem_addr + PC_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == FETCH) || (state_d == DECODE) ||
                (state_d == ISSUE);
    halted_d  = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_addr <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_rd    <= '0;
      iss_rs    <= '0;
      iss_imm   <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      icount    <= '0;
    end else begin
      state     <= state_d;
      imem_addr <= pc_d;
      iss_valid <= valid_d;
      iss_op    <= op_d;
      iss_rd    <= rd_d;
      iss_rs    <= rs_d;
      iss_imm   <= imm_d;
      running   <= running_d;
      halted    <= halted_d;
      illegal   <= illegal_d;
      icount    <= icount_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: vector table for the basic program,
// hand sequences for stall, illegal, wrap, reset and restart cases.
module tb_alu_issue_seq;

  localparam int PW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          iss_valid;
  logic          iss_ready;
  logic [3:0]    iss_op;
  logic [1:0]    iss_rd;
  logic [1:0]    iss_rs;
  logic [5:0]    iss_imm;
  logic          running;
  logic          halted;
  logic          illegal;
  logic [15:0]   icount;

  logic [15:0] rom [4];

  int n_chk = 0;
  int n_fail = 0;

  alu_issue_seq #(.PC_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_op     (iss_op),
    .iss_rd     (iss_rd),
    .iss_rs     (iss_rs),
    .iss_imm    (iss_imm),
    .running    (running),
    .halted     (halted),
    .illegal    (illegal),
    .icount     (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM: data appears one cycle after the address
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [5:0] imm;
    logic       run;
    logic       hlt;
    logic [1:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    iss_ready = 1'b0;
    rom[0] = 16'h7406;
    rom[1] = 16'hD000;
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;

    //          st ry vl op     rd rs imm    rn hl ad cnt
    tbl[0] = '{1, 1, 0, 4'h0, 0, 0, 6'h0, 1, 0, 0, 16'd0};
    tbl[1] = '{0, 1, 0, 4'h0, 0, 0, 6'h0, 1, 0, 0, 16'd0};
    tbl[2] = '{0, 1, 1, 4'h7, 1, 0, 6'h6, 1, 0, 0, 16'd0};
    tbl[3] = '{0, 1, 0, 4'h7, 1, 0, 6'h6, 1, 0, 1, 16'd1};
    tbl[4] = '{0, 1, 0, 4'h7, 1, 0, 6'h6, 1, 0, 1, 16'd1};
    tbl[5] = '{0, 1, 1, 4'hD, 0, 0, 6'h0, 1, 0, 1, 16'd1};
    tbl[6] = '{0, 1, 0, 4'hD, 0, 0, 6'h0, 0, 1, 1, 16'd2};
    tbl[7] = '{0, 1, 0, 4'hD, 0, 0, 6'h0, 0, 1, 1, 16'd2};

    // reset state
    reset = 1'b1;
    iss_ready = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_valid", iss_valid, 0);
    chk("rst_op", iss_op, 0);
    chk("rst_rd", iss_rd, 0);
    chk("rst_rs", iss_rs, 0);
    chk("rst_imm", iss_imm, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_run", running, 0);
    chk("rst_hlt", halted, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_cnt", icount, 0);

    // basic program: ADD then HALT
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start;
      iss_ready = tbl[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), iss_valid, tbl[i].valid);
      chk($sformatf("v%0d_op", i), iss_op, tbl[i].op);
      chk($sformatf("v%0d_rd", i), iss_rd, tbl[i].rd);
      chk($sformatf("v%0d_rs", i), iss_rs, tbl[i].rs);
      chk($sformatf("v%0d_imm", i), iss_imm, tbl[i].imm);
      chk($sformatf("v%0d_run", i), running, tbl[i].run);
      chk($sformatf("v%0d_hlt", i), halted, tbl[i].hlt);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_cnt", i), icount, tbl[i].cnt);
      chk($sformatf("v%0d_ill", i), illegal, 0);
    end

    // restart from HALTED, start ignored in FETCH and DECODE, then stall
    iss_ready = 1'b0;
    start = 1'b1;
    step();
    chk("rs_run", running, 1);
    chk("rs_hlt", halted, 0);
    chk("rs_addr", imem_addr, 0);
    chk("rs_cnt", icount, 0);
    step();
    chk("rs_dec_run", running, 1);
    chk("rs_dec_valid", iss_valid, 0);
    step();
    start = 1'b0;
    chk("rs_iss_valid", iss_valid, 1);
    chk("rs_iss_op", iss_op, 7);
    chk("rs_iss_addr", imem_addr, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("st%0d_valid", i), iss_valid, 1);
      chk($sformatf("st%0d_op", i), iss_op, 7);
      chk($sformatf("st%0d_rd", i), iss_rd, 1);
      chk($sformatf("st%0d_imm", i), iss_imm, 6);
      chk($sformatf("st%0d_addr", i), imem_addr, 0);
      chk($sformatf("st%0d_cnt", i), icount, 0);
    end
    iss_ready = 1'b1;
    step();
    chk("st_acc_valid", iss_valid, 0);
    chk("st_acc_cnt", icount, 1);
    chk("st_acc_addr", imem_addr, 1);

    // reset during ISSUE with ready high discards the instruction
    do_reset();
    iss_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ri_valid_pre", iss_valid, 1);
    reset = 1'b1;
    iss_ready = 1'b1;
    step();
    reset = 1'b0;
    chk("ri_valid", iss_valid, 0);
    chk("ri_cnt", icount, 0);
    chk("ri_run", running, 0);
    step();
    chk("ri_idle_run", running, 0);
    chk("ri_idle_cnt", icount, 0);

    // illegal opcode skipped, next instruction issued
    rom[0] = 16'hE000;
    rom[1] = 16'hBC3F;
    iss_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("il_pre", illegal, 0);
    step();
    chk("il_pulse", illegal, 1);
    chk("il_valid", iss_valid, 0);
    chk("il_addr", imem_addr, 1);
    chk("il_cnt", icount, 0);
    step();
    chk("il_clear", illegal, 0);
    step();
    chk("il_iss_valid", iss_valid, 1);
    chk("il_iss_op", iss_op, 4'hB);
    chk("il_iss_rd", iss_rd, 3);
    chk("il_iss_rs", iss_rs, 0);
    chk("il_iss_imm", iss_imm, 6'h3F);
    chk("il_iss_ill", illegal, 0);
    iss_ready = 1'b1;
    step();
    chk("il_acc_cnt", icount, 1);
    chk("il_acc_valid", iss_valid, 0);

    // pc wrap with a 2-bit pc and no HALT in the ROM
    do_reset();
    for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
    iss_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wr%0d_addr", i), imem_addr, i % 4);
      chk($sformatf("wr%0d_run", i), running, 1);
      step();
      step();
      chk($sformatf("wr%0d_valid", i), iss_valid, 1);
      chk($sformatf("wr%0d_op", i), iss_op, 0);
      step();
    end
    chk("wr_cnt", icount, 5);
    chk("wr_addr_end", imem_addr, 1);
    chk("wr_hlt", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001: Parameter PC_W, default 8, program counter and instruction-memory address width.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  single-cycle request to begin execution at address 0.
REQ-005: imem_addr  output  PC_W  instruction-memory read address.
REQ-006: imem_rdata  input  16  instruction word, valid exactly one cycle after imem_addr is presented (registered ROM).
REQ-007: iss_valid  output  1  instruction fields on iss_* are valid for the ALU pipeline.
REQ-008: iss_ready  input  1  ALU pipeline accepts the instruction this cycle.
REQ-009: iss_op  output  4  opcode (0x0 OR .. 0xC OUT, 0xD HALT).
REQ-010: iss_rd  output  2  destination / Rx register address.
REQ-011: iss_rs  output  2  source / Ry register address.
REQ-012: iss_imm  output  6  immediate for LOADLO/LOADHI.
REQ-013: running  output  1  high in FETCH, DECODE or ISSUE.
REQ-014: halted  output  1  high in HALTED.
REQ-015: illegal  output  1  one-cycle pulse when opcode 0xE/0xF is fetched.
REQ-016: icount  output  16  count of accepted instructions.

Function
REQ-017: Instruction format: op=[15:12], rd=[11:10], rs=[9:8], [7:6] ignored, imm=[5:0].
REQ-018: States IDLE, FETCH, DECODE, ISSUE, HALTED; all outputs registered.
REQ-019: IDLE: start=1 -> pc<=0, icount<=0, next FETCH; otherwise stay.
REQ-020: FETCH: imem_addr=pc; next DECODE unconditionally.
REQ-021: DECODE: imem_rdata sampled; opcode 0x0-0xD -> fields latched into iss_* and next ISSUE with iss_valid=1 from the first ISSUE cycle.
REQ-022: DECODE with opcode 0xE/0xF -> illegal pulses for one cycle, nothing issued, icount unchanged, pc<=pc+1, next FETCH.
REQ-023: ISSUE: iss_valid and all iss_* fields held stable until the cycle iss_valid&iss_ready=1 (handshake).
REQ-024: Handshake with iss_op!=0xD -> icount+1, pc<=pc+1, iss_valid<=0, next FETCH; minimum 3 cycles per instruction.
REQ-025: Handshake with iss_op=0xD -> icount+1, iss_valid<=0, pc unchanged, next HALTED.
REQ-026: HALTED: no fetch, iss_valid=0; start=1 -> restart as in REQ-019.
REQ-027: start ignored in FETCH, DECODE, ISSUE.
REQ-028: pc wraps from 2^PC_W-1 to 0 with no other effect.
REQ-029: icount saturates at 0xFFFF.
REQ-030: imem_addr equals pc in every state (don't-care outside FETCH but driven).
REQ-031: iss_ready while iss_valid=0 has no effect.

Reset
REQ-032: reset=1 at a rising edge -> state IDLE, pc=0, imem_addr=0, iss_valid=0, iss_op=0, iss_rd=0, iss_rs=0, iss_imm=0, running=0, halted=0, illegal=0, icount=0.
REQ-033: reset overrides start and any in-flight handshake in the same cycle; a pending instruction is discarded, not issued.
REQ-034: Before the first reset edge outputs are undefined; no requirement.

Verification
REQ-035: reset, then start; ROM[0]=0x7406 (ADD rd=1 rs=0), ROM[1]=0xD000, iss_ready=1 -> iss_valid at cycle 3 after start with op=7 rd=1 rs=0 imm=6; then op=D issued, halted=1, icount=2.
REQ-036: iss_ready=0 for 5 cycles during ISSUE -> iss_valid and iss_* stable for all 5 cycles, pc unchanged, icount unchanged; accepted on first iss_ready=1.
REQ-037: ROM[0]=0xE000, ROM[1]=0xBC3F -> illegal pulses once, first issued op=B rd=3 rs=0 imm=0x3F, icount=1 after handshake.
REQ-038: PC_W=2, ROM all 0x0000 except none HALT -> pc sequence 0,1,2,3,0; no stall or error at wrap.
REQ-039: reset asserted in ISSUE with iss_ready=1 same cycle -> icount stays 0, iss_valid=0 next cycle, state IDLE.
REQ-040: start pulsed in FETCH and DECODE ignored; start in HALTED restarts at pc=0 with icount=0.
